fetch_queue: RTL and testbench

- Instruction buffer directly downstream of the IF stage and instruction ROM.
- Captures each fetched 9-bit instruction together with its PC, and presents them in order to the decode stage through a valid/ready handshake.
- Decouples fetch from decode stalls.
- Supports a flush on a taken branch, and stops accepting new instructions once a HALT instruction has been enqueued.

---
 rtl/fetch_queue_pkg.sv | 5 +
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue_storage.sv | 18 +
 rtl/fetch_queue.sv | 67 ++++++
 tb/tb_fetch_queue.sv | 131 +++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared instruction width and HALT encoding for the fetch queue slice
package fetch_pkg;
  localparam int INST_W = 9;
  localparam logic [INST_W-1:0] HALT_INST = 9'b111111111;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IF-side push, decode-side pop, flush and status signals of the fetch queue
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int A     = 4,
  parameter int DEPTH = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [INST_W-1:0]            in_inst;
  logic [A-1:0]                 in_pc;
  logic                         out_valid;
  logic                         out_ready;
  logic [INST_W-1:0]            out_inst;
  logic [A-1:0]                 out_pc;
  logic                         flush;
  logic                         halted;
  logic [$clog2(DEPTH+1)-1:0]   count;
  modport master (
    output in_valid, in_inst, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_inst, out_pc, halted, count
  );
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready, flush,
    output in_ready, out_valid, out_inst, out_pc, halted, count
  );
endinterface

// File: rtl/fetch_queue_storage.sv
// fq_storage: DEPTH x W register array, one write port, one asynchronous read port, no reset
module fq_storage #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  // write the addressed entry on a push
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between IF and decode with flush and HALT stop.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming instruction with 0-cycle latency.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int A     = 4,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  fetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [A-1:0]      pc;
  } fq_entry_t;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          halt_q;
  logic          accept, push, pop, bypass, has_data;
  fq_entry_t     wr_e, rd_e;
  assign has_data   = cnt != '0;
  assign q.in_ready = (cnt != CW'(DEPTH)) && !halt_q;
  assign accept     = q.in_valid && q.in_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = !has_data && q.in_valid && !halt_q && !q.flush;
`else
  assign bypass = 1'b0;
`endif
  // a bypassed instruction taken by decode the same cycle never enters storage
  assign push        = accept && !(bypass && q.out_ready);
  assign pop         = has_data && q.out_ready;
  assign wr_e        = '{inst: q.in_inst, pc: q.in_pc};
  assign q.out_valid = has_data || bypass;
  assign q.out_inst  = bypass ? q.in_inst : has_data ? rd_e.inst : '0;
  assign q.out_pc    = bypass ? q.in_pc : has_data ? rd_e.pc : '0;
  assign q.count     = cnt;
  assign q.halted    = halt_q;
  fq_storage #(.W($bits(fq_entry_t)), .DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (push && !q.flush),
    .waddr (wr_ptr),
    .wdata (wr_e),
    .raddr (rd_ptr),
    .rdata (rd_e)
  );
  // pointer, occupancy and halt state; flush discards everything including this cycle's push/pop
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      halt_q <= 1'b0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      halt_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (accept && q.in_inst == HALT_INST) halt_q <= 1'b1;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed checks of fetch_queue plus reset, latency and bypass sequences
module tb_fetch_queue;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  fetch_queue_if #(.A(4), .DEPTH(4)) q ();
  fetch_queue #(.A(4), .DEPTH(4)) dut (.clk(clk), .reset(reset), .q(q));
  // free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;
  typedef struct {
    logic       iv;
    logic [8:0] inst;
    logic [3:0] pc;
    logic       ordy;
    logic       fl;
    logic [2:0] e_cnt;
    logic       e_ov;
    logic       e_ir;
    logic       e_h;
    logic [8:0] e_inst;
    logic [3:0] e_pc;
  } vec_t;
  vec_t vecs[$];
  function automatic void add(logic iv, logic [8:0] inst, logic [3:0] pc, logic ordy, logic fl,
                              logic [2:0] c, logic ov, logic ir, logic h, logic [8:0] oi, logic [3:0] op);
    vec_t v;
    v.iv = iv; v.inst = inst; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.e_cnt = c; v.e_ov = ov; v.e_ir = ir; v.e_h = h; v.e_inst = oi; v.e_pc = op;
    vecs.push_back(v);
  endfunction
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask
  task automatic idle();
    q.in_valid = 1'b0; q.in_inst = '0; q.in_pc = '0; q.out_ready = 1'b0; q.flush = 1'b0;
  endtask
  task automatic chk_state(string tag, int idx, logic [2:0] c, logic ov, logic ir, logic h, logic [8:0] oi, logic [3:0] op);
    chk({tag, ".count"}, idx, 32'(q.count), 32'(c));
    chk({tag, ".out_valid"}, idx, 32'(q.out_valid), 32'(ov));
    chk({tag, ".in_ready"}, idx, 32'(q.in_ready), 32'(ir));
    chk({tag, ".halted"}, idx, 32'(q.halted), 32'(h));
    chk({tag, ".out_inst"}, idx, 32'(q.out_inst), 32'(oi));
    chk({tag, ".out_pc"}, idx, 32'(q.out_pc), 32'(op));
  endtask
  initial begin
    idle();
    // fill pc 0..3, then a refused push while full
    add(1, 9'h001, 4'd0, 0, 0, 3'd1, 1, 1, 0, 9'h001, 4'd0);
    add(1, 9'h002, 4'd1, 0, 0, 3'd2, 1, 1, 0, 9'h001, 4'd0);
    add(1, 9'h003, 4'd2, 0, 0, 3'd3, 1, 1, 0, 9'h001, 4'd0);
    add(1, 9'h004, 4'd3, 0, 0, 3'd4, 1, 0, 0, 9'h001, 4'd0);
    add(1, 9'h005, 4'd4, 0, 0, 3'd4, 1, 0, 0, 9'h001, 4'd0);
    // drain in order, then a pop on empty is ignored
    add(0, 9'h000, 4'd0, 1, 0, 3'd3, 1, 1, 0, 9'h002, 4'd1);
    add(0, 9'h000, 4'd0, 1, 0, 3'd2, 1, 1, 0, 9'h003, 4'd2);
    add(0, 9'h000, 4'd0, 1, 0, 3'd1, 1, 1, 0, 9'h004, 4'd3);
    add(0, 9'h000, 4'd0, 1, 0, 3'd0, 0, 1, 0, 9'h000, 4'd0);
    add(0, 9'h000, 4'd0, 1, 0, 3'd0, 0, 1, 0, 9'h000, 4'd0);
    // entry j carries inst 9'h010+j, pc (8+j) mod 16; stream at count=2 for 10 cycles
    add(1, 9'h010, 4'd8, 0, 0, 3'd1, 1, 1, 0, 9'h010, 4'd8);
    add(1, 9'h011, 4'd9, 0, 0, 3'd2, 1, 1, 0, 9'h010, 4'd8);
    for (int k = 0; k < 10; k++)
      add(1, 9'(9'h012 + k), 4'((10 + k) % 16), 1, 0, 3'd2, 1, 1, 0, 9'(9'h011 + k), 4'((9 + k) % 16));
    add(1, 9'h01C, 4'd4, 0, 0, 3'd3, 1, 1, 0, 9'h01A, 4'd2);
    add(1, 9'h01D, 4'd5, 0, 0, 3'd4, 1, 0, 0, 9'h01A, 4'd2);
    // full with pop and push: push refused, slot frees for next cycle only
    add(1, 9'h01E, 4'd6, 1, 0, 3'd3, 1, 1, 0, 9'h01B, 4'd3);
    // flush with 3 entries and a push of pc 5
    add(1, 9'h055, 4'd5, 0, 1, 3'd0, 0, 1, 0, 9'h000, 4'd0);
    // halt: HALT stored, later push refused, drain, flush clears halted
    add(1, 9'h010, 4'd1, 0, 0, 3'd1, 1, 1, 0, 9'h010, 4'd1);
    add(1, 9'h1FF, 4'd2, 0, 0, 3'd2, 1, 0, 1, 9'h010, 4'd1);
    add(1, 9'h020, 4'd7, 0, 0, 3'd2, 1, 0, 1, 9'h010, 4'd1);
    add(0, 9'h000, 4'd0, 1, 0, 3'd1, 1, 0, 1, 9'h1FF, 4'd2);
    add(0, 9'h000, 4'd0, 1, 0, 3'd0, 0, 0, 1, 9'h000, 4'd0);
    add(0, 9'h000, 4'd0, 0, 1, 3'd0, 0, 1, 0, 9'h000, 4'd0);
    // reset held low for 2 cycles, released away from the edge
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk_state("reset", 0, 3'd0, 0, 1, 0, 9'h000, 4'd0);
    foreach (vecs[i]) begin
      q.in_valid = vecs[i].iv; q.in_inst = vecs[i].inst; q.in_pc = vecs[i].pc;
      q.out_ready = vecs[i].ordy; q.flush = vecs[i].fl;
      @(posedge clk);
      #1 idle();
      #1 chk_state("vec", i, vecs[i].e_cnt, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_h, vecs[i].e_inst, vecs[i].e_pc);
    end
    // push-to-output latency on an empty queue with decode ready
    @(negedge clk);
    q.in_valid = 1'b1; q.in_inst = 9'h0AB; q.in_pc = 4'hC; q.out_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass.out_valid", 0, 32'(q.out_valid), 32'd1);
    chk("bypass.out_inst", 0, 32'(q.out_inst), 32'h0AB);
    chk("bypass.out_pc", 0, 32'(q.out_pc), 32'hC);
    @(posedge clk);
    #1 idle();
    #1 chk_state("bypass_after", 0, 3'd0, 0, 1, 0, 9'h000, 4'd0);
`else
    chk("latency.out_valid_same", 0, 32'(q.out_valid), 32'd0);
    @(posedge clk);
    #1 idle();
    #1 chk_state("latency_next", 0, 3'd1, 1, 1, 0, 9'h0AB, 4'hC);
    q.out_ready = 1'b1;
    @(posedge clk);
    #1 idle();
    #1 chk_state("latency_pop", 0, 3'd0, 0, 1, 0, 9'h000, 4'd0);
`endif
    // asynchronous reset mid-operation drops entries immediately
    @(negedge clk);
    q.in_valid = 1'b1; q.in_inst = 9'h033; q.in_pc = 4'd3;
    repeat (2) @(posedge clk);
    #1 idle();
    #1 chk("midrst.count_before", 0, 32'(q.count), 32'd2);
    #1 reset = 1'b0;
    #1 chk_state("midrst", 0, 3'd0, 0, 1, 0, 9'h000, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_state("post_rst", 0, 3'd0, 0, 1, 0, 9'h000, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
